// File: rtl/planta_ascensor.sv
// Behavioural cabin/door plant: turns motor and door commands into floor-change pulses,
// door state and obstacle sensing for closed-loop controller benches.
module planta_ascensor #(
    parameter int T_PISO       = 16,
    parameter int T_PUERTA     = 8,
    parameter int PISO_INICIAL = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] motor,
    input  logic [1:0] puertas,
    input  logic       obstaculo,
    output logic       cambio_piso,
    output logic [1:0] estado_puertas,
    output logic       sensor_puertas,
    output logic [1:0] piso,
    output logic       en_piso,
    output logic       falla
);

    localparam int OW = (T_PISO > 2) ? $clog2(T_PISO) : 1;
    localparam int DW = (T_PUERTA > 2) ? $clog2(T_PUERTA) : 1;
    localparam logic [OW-1:0] OFF_MAX   = OW'(T_PISO - 1);
    localparam logic [DW-1:0] DCNT_MAX  = DW'(T_PUERTA - 1);
    localparam logic [1:0]    PISO_RST  = 2'(PISO_INICIAL);

    localparam logic [1:0] CERRADA  = 2'b00;
    localparam logic [1:0] ABRIENDO = 2'b01;
    localparam logic [1:0] ABIERTA  = 2'b10;
    localparam logic [1:0] CERRANDO = 2'b11;

    logic [OW-1:0] off_reg, off_next;
    logic [DW-1:0] dcnt_reg, dcnt_next;
    logic [1:0]    piso_next, estado_next;
    logic          cambio_next, sensor_next, en_piso_next, falla_next;
    logic          motor_up, motor_dn, motor_stop;

    assign motor_up   = (motor == 2'b01);
    assign motor_dn   = (motor == 2'b10);
    assign motor_stop = !motor_up && !motor_dn;

    always_comb begin
        piso_next   = piso;
        off_next    = off_reg;
        cambio_next = 1'b0;
        estado_next = estado_puertas;
        dcnt_next   = dcnt_reg;
        falla_next  = falla;

        if (motor == 2'b11)
            falla_next = 1'b1;

        // Motion uses the door state as it stands this cycle, before any door update.
        if (!motor_stop) begin
            if (estado_puertas != CERRADA) begin
                falla_next = 1'b1;
            end else if (!falla) begin
                if (motor_up) begin
                    if (off_reg == OFF_MAX) begin
                        piso_next   = piso + 2'd1;
                        off_next    = '0;
                        cambio_next = 1'b1;
                    end else if (off_reg == '0 && piso == 2'd3) begin
                        falla_next = 1'b1;
                    end else begin
                        off_next = off_reg + OW'(1);
                    end
                end else begin
                    if (off_reg > OW'(1)) begin
                        off_next = off_reg - OW'(1);
                    end else if (off_reg == OW'(1)) begin
                        off_next    = '0;
                        cambio_next = 1'b1;
                    end else if (piso != 2'd0) begin
                        piso_next = piso - 2'd1;
                        off_next  = OFF_MAX;
                    end else begin
                        falla_next = 1'b1;
                    end
                end
            end
        end

        // A reversal mirrors the stroke counter so the door resumes from where it is.
        case (estado_puertas)
            CERRADA: begin
                if (puertas == 2'b01) begin
                    if (en_piso && motor_stop) begin
                        estado_next = ABRIENDO;
                        dcnt_next   = '0;
                    end else begin
                        falla_next = 1'b1;
                    end
                end
            end
            ABRIENDO: begin
                if (puertas == 2'b10) begin
                    estado_next = CERRANDO;
                    dcnt_next   = DCNT_MAX - dcnt_reg;
                end else if (dcnt_reg == DCNT_MAX) begin
                    estado_next = ABIERTA;
                    dcnt_next   = '0;
                end else begin
                    dcnt_next = dcnt_reg + DW'(1);
                end
            end
            ABIERTA: begin
                if (puertas == 2'b10) begin
                    estado_next = CERRANDO;
                    dcnt_next   = '0;
                end
            end
            default: begin
                if (obstaculo || puertas == 2'b01) begin
                    estado_next = ABRIENDO;
                    dcnt_next   = DCNT_MAX - dcnt_reg;
                end else if (dcnt_reg == DCNT_MAX) begin
                    estado_next = CERRADA;
                    dcnt_next   = '0;
                end else begin
                    dcnt_next = dcnt_reg + DW'(1);
                end
            end
        endcase

        sensor_next  = obstaculo && (estado_puertas != CERRADA);
        en_piso_next = (off_next == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            piso           <= PISO_RST;
            off_reg        <= '0;
            en_piso        <= 1'b1;
            estado_puertas <= CERRADA;
            dcnt_reg       <= '0;
            cambio_piso    <= 1'b0;
            sensor_puertas <= 1'b0;
            falla          <= 1'b0;
        end else begin
            piso           <= piso_next;
            off_reg        <= off_next;
            en_piso        <= en_piso_next;
            estado_puertas <= estado_next;
            dcnt_reg       <= dcnt_next;
            cambio_piso    <= cambio_next;
            sensor_puertas <= sensor_next;
            falla          <= falla_next;
        end
    end

endmodule

// File: tb/tb_planta_ascensor.sv
// Directed bench for planta_ascensor with T_PISO=4, T_PUERTA=4, starting at floor 0.
module tb_planta_ascensor;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] motor = 2'b00;
    logic [1:0] puertas = 2'b00;
    logic       obstaculo = 1'b0;
    logic       cambio_piso, sensor_puertas, en_piso, falla;
    logic [1:0] estado_puertas, piso;

    int n_checks = 0;
    int n_fail   = 0;

    planta_ascensor #(.T_PISO(4), .T_PUERTA(4), .PISO_INICIAL(0)) dut (
        .clk            (clk),
        .reset          (reset),
        .motor          (motor),
        .puertas        (puertas),
        .obstaculo      (obstaculo),
        .cambio_piso    (cambio_piso),
        .estado_puertas (estado_puertas),
        .sensor_puertas (sensor_puertas),
        .piso           (piso),
        .en_piso        (en_piso),
        .falla          (falla)
    );

    always #5 clk = ~clk;

    // Expected outputs packed as {piso[1:0], en_piso, cambio_piso, estado[1:0], sensor, falla}
    typedef struct {
        logic [1:0] m;
        logic [1:0] p;
        logic       o;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [7:0] e(input logic [1:0] pi, input logic en, input logic cp,
                                     input logic [1:0] es, input logic se, input logic fa);
        return {pi, en, cp, es, se, fa};
    endfunction

    function automatic vec_t v(input logic [1:0] m, input logic [1:0] p, input logic o,
                               input logic [7:0] ex);
        vec_t r;
        r.m = m; r.p = p; r.o = o; r.exp = ex;
        return r;
    endfunction

    task automatic check(input string name, input logic [7:0] ex);
        logic [7:0] got;
        got = {piso, en_piso, cambio_piso, estado_puertas, sensor_puertas, falla};
        n_checks++;
        if (got !== ex) begin
            n_fail++;
            $display("FAIL %s: got %b required %b (piso,en_piso,cambio,estado,sensor,falla)",
                     name, got, ex);
        end else begin
            $display("ok   %s: %b", name, got);
        end
    endtask

    task automatic step(input logic [1:0] m, input logic [1:0] p, input logic o);
        motor = m; puertas = p; obstaculo = o;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        motor = 2'b00; puertas = 2'b00; obstaculo = 1'b0;
        reset = 1'b1;
        #1;
        reset = 1'b0;
    endtask

    initial begin
        // Upward travel: 3 cycles between floors, pulse on arrival
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < 3; k++) tbl.push_back(v(2'b01, 2'b00, 1'b0, e(2'(f), 1'b0, 1'b0, 2'b00, 1'b0, 1'b0)));
            tbl.push_back(v(2'b01, 2'b00, 1'b0, e(2'(f + 1), 1'b1, 1'b1, 2'b00, 1'b0, 1'b0)));
        end
        // Down from 3 to 2, then down/up around a floor level
        tbl.push_back(v(2'b10, 2'b00, 1'b0, e(2'd2, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0)));
        tbl.push_back(v(2'b10, 2'b00, 1'b0, e(2'd2, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0)));
        tbl.push_back(v(2'b10, 2'b00, 1'b0, e(2'd2, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0)));
        tbl.push_back(v(2'b10, 2'b00, 1'b0, e(2'd2, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0)));
        tbl.push_back(v(2'b10, 2'b00, 1'b0, e(2'd1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0)));
        tbl.push_back(v(2'b01, 2'b00, 1'b0, e(2'd2, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0)));
        tbl.push_back(v(2'b00, 2'b00, 1'b0, e(2'd2, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0)));
        tbl.push_back(v(2'b00, 2'b00, 1'b0, e(2'd2, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0)));
        // Open stroke: 4 cycles opening, then open
        tbl.push_back(v(2'b00, 2'b01, 1'b0, e(2'd2, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0)));
        for (int k = 0; k < 3; k++) tbl.push_back(v(2'b00, 2'b00, 1'b0, e(2'd2, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0)));
        tbl.push_back(v(2'b00, 2'b00, 1'b0, e(2'd2, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0)));
        // Close, obstacle at dcnt=1 reverses, reopens after 2 more cycles
        tbl.push_back(v(2'b00, 2'b10, 1'b0, e(2'd2, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0)));
        tbl.push_back(v(2'b00, 2'b00, 1'b0, e(2'd2, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0)));
        tbl.push_back(v(2'b00, 2'b00, 1'b1, e(2'd2, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0)));
        tbl.push_back(v(2'b00, 2'b00, 1'b0, e(2'd2, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0)));
        tbl.push_back(v(2'b00, 2'b00, 1'b0, e(2'd2, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0)));
        // Full close stroke
        tbl.push_back(v(2'b00, 2'b10, 1'b0, e(2'd2, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0)));
        for (int k = 0; k < 3; k++) tbl.push_back(v(2'b00, 2'b00, 1'b0, e(2'd2, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0)));
        tbl.push_back(v(2'b00, 2'b00, 1'b0, e(2'd2, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0)));
        // Obstacle with door closed is masked
        tbl.push_back(v(2'b00, 2'b00, 1'b1, e(2'd2, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0)));
        tbl.push_back(v(2'b00, 2'b00, 1'b0, e(2'd2, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0)));
        // Reopen, then motor up with doors open faults and holds position
        tbl.push_back(v(2'b00, 2'b01, 1'b0, e(2'd2, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0)));
        for (int k = 0; k < 3; k++) tbl.push_back(v(2'b00, 2'b00, 1'b0, e(2'd2, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0)));
        tbl.push_back(v(2'b00, 2'b00, 1'b0, e(2'd2, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0)));
        tbl.push_back(v(2'b01, 2'b00, 1'b0, e(2'd2, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1)));
        tbl.push_back(v(2'b00, 2'b00, 1'b0, e(2'd2, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1)));
        tbl.push_back(v(2'b01, 2'b00, 1'b0, e(2'd2, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1)));

        #1 reset = 1'b1;
        #1 check("reset_state", e(2'd0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0));
        @(posedge clk);
        #1 reset = 1'b0;

        foreach (tbl[i]) begin
            step(tbl[i].m, tbl[i].p, tbl[i].o);
            check($sformatf("vec%0d", i), tbl[i].exp);
        end

        // Up at the top floor
        do_reset();
        repeat (12) step(2'b01, 2'b00, 1'b0);
        check("reach_top", e(2'd3, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0));
        step(2'b01, 2'b00, 1'b0);
        check("up_at_top", e(2'd3, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1));
        step(2'b00, 2'b00, 1'b0);
        check("falla_sticky", e(2'd3, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1));

        // Down at the bottom floor
        do_reset();
        step(2'b10, 2'b00, 1'b0);
        check("down_at_bottom", e(2'd0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1));

        // Illegal motor code, then motion frozen but doors still work
        do_reset();
        step(2'b11, 2'b00, 1'b0);
        check("motor_11", e(2'd0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1));
        step(2'b01, 2'b00, 1'b0);
        check("halt_after_falla", e(2'd0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1));
        step(2'b00, 2'b01, 1'b0);
        check("door_after_falla", e(2'd0, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1));

        // Open command between floors
        do_reset();
        step(2'b01, 2'b00, 1'b0);
        step(2'b00, 2'b01, 1'b0);
        check("open_midtravel", e(2'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1));

        // Move and open together: cabin moves, open ignored
        do_reset();
        step(2'b01, 2'b01, 1'b0);
        check("move_and_open", e(2'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1));

        // Async reset one cycle before arrival: no pulse
        do_reset();
        repeat (3) step(2'b01, 2'b00, 1'b0);
        check("pre_reset_travel", e(2'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0));
        #2 reset = 1'b1;
        #1 check("async_reset_travel", e(2'd0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0));
        @(posedge clk);
        #1 check("reset_hold_no_pulse", e(2'd0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0));
        reset = 1'b0;

        // Async reset mid-stroke with sensor active
        do_reset();
        step(2'b00, 2'b01, 1'b0);
        step(2'b00, 2'b00, 1'b1);
        check("sensor_opening", e(2'd0, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0));
        #2 reset = 1'b1;
        #1 check("async_reset_stroke", e(2'd0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0));
        reset = 1'b0;
        obstaculo = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
